// File: rtl/id_operand_bypass.sv
// Decode-stage pipeline register with zero-cycle operand bypass and load-use interlock.
// Each source operand is taken from the youngest matching producer. Decode stalls only when
// that producer has no result yet.
// Optional feature: define DS_STALL_CNT_EN to add the saturating stall_cnt counter and its port.
module id_operand_bypass #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned NUM_FWD = 3,
  parameter int unsigned BUS_W   = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fs_to_ds_valid,
  input  logic [BUS_W-1:0]           fs_to_ds_bus,
  output logic                       ds_allowin,
  input  logic                       es_allowin,
  output logic                       ds_to_es_valid,
  output logic [BUS_W-1:0]           ds_bus,
  input  logic                       ds_flush,
  input  logic [REG_AW-1:0]          rs_addr,
  input  logic [REG_AW-1:0]          rt_addr,
  input  logic                       rs_used,
  input  logic                       rt_used,
  input  logic [DATA_W-1:0]          rf_rdata1,
  input  logic [DATA_W-1:0]          rf_rdata2,
  input  logic [NUM_FWD-1:0]         fwd_valid,
  input  logic [NUM_FWD*REG_AW-1:0]  fwd_dest,
  input  logic [NUM_FWD-1:0]         fwd_ready,
  input  logic [NUM_FWD*DATA_W-1:0]  fwd_data,
  output logic [DATA_W-1:0]          rs_value,
  output logic [DATA_W-1:0]          rt_value,
  output logic                       ds_stall
`ifdef DS_STALL_CNT_EN
  ,
  output logic [31:0]                stall_cnt
`endif
);

  logic             ds_valid;
  logic [BUS_W-1:0] ds_bus_r;
  logic             rs_found, rt_found;
  logic             rs_pend, rt_pend;
  logic             ds_ready_go;

  // Per-source bypass mux: the first (youngest) matching producer wins; register 0 always reads zero
  always_comb begin
    rs_value = rf_rdata1;
    rt_value = rf_rdata2;
    rs_found = 1'b0;
    rt_found = 1'b0;
    rs_pend  = 1'b0;
    rt_pend  = 1'b0;
    for (int unsigned i = 0; i < NUM_FWD; i++) begin
      if (!rs_found && fwd_valid[i] && fwd_dest[i*REG_AW +: REG_AW] == rs_addr) begin
        rs_found = 1'b1;
        rs_value = fwd_data[i*DATA_W +: DATA_W];
        rs_pend  = !fwd_ready[i];
      end
      if (!rt_found && fwd_valid[i] && fwd_dest[i*REG_AW +: REG_AW] == rt_addr) begin
        rt_found = 1'b1;
        rt_value = fwd_data[i*DATA_W +: DATA_W];
        rt_pend  = !fwd_ready[i];
      end
    end
    if (rs_addr == '0) begin
      rs_value = '0;
      rs_pend  = 1'b0;
    end
    if (rt_addr == '0) begin
      rt_value = '0;
      rt_pend  = 1'b0;
    end
  end

  // Interlock and handshake: stall only on a used source whose winning producer is not ready
  always_comb begin
    ds_ready_go    = !((rs_used && rs_pend) || (rt_used && rt_pend));
    ds_allowin     = !ds_valid || (ds_ready_go && es_allowin);
    ds_to_es_valid = ds_valid && ds_ready_go;
    ds_stall       = ds_valid && !ds_ready_go;
    ds_bus         = ds_bus_r;
  end

  // Valid bit: flush wins over an incoming payload
  always_ff @(posedge clk) begin
    if (reset)           ds_valid <= 1'b0;
    else if (ds_flush)   ds_valid <= 1'b0;
    else if (ds_allowin) ds_valid <= fs_to_ds_valid;
  end

  // Payload register: capture only an accepted, non-flushed payload
  always_ff @(posedge clk) begin
    if (reset)
      ds_bus_r <= '0;
    else if (fs_to_ds_valid && ds_allowin && !ds_flush)
      ds_bus_r <= fs_to_ds_bus;
  end

`ifdef DS_STALL_CNT_EN
  // Saturating count of interlock stall cycles, excluding cycles where the stalled instruction is killed
  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if (ds_stall && !ds_flush && stall_cnt != '1)
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule
